hardwired_control_unit: RTL and testbench
=========================================

# hardwired_control_unit

Hardwired control unit that drives every control input of the arithmetic-logic-unit datapath (RF, ALU, ARF, IR, memory, MUX A/B/C). It consumes `IROut` and `ALUOutFlag` from that datapath and sequences fetch/decode/execute with a timing counter and a small state machine. It is the sole source of datapath control in the CPU top level.

## Interface
Parameters:
- `T_W`, default 3: width of the timing counter T.

Ports:
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: reset is synchronous and active-high.
- `IROut` in 16: instruction register contents.
  - [15:10] opcode; [9:8] Rx (00=R1…11=R4); [7:0] immediate/address.
- `ALUOutFlag` in 4: {Z,C,N,O}; bit 3 = Z.
- `RF_OutASel`, `RF_OutBSel` out 3 each.
- `RF_FunSel` out 3; `RF_RegSel` out 4; `RF_ScrSel` out 4.
- `ALU_FunSel` out 5; `ALU_WF` out 1.
- `ARF_OutCSel`, `ARF_OutDSel` out 2 each.
- `ARF_FunSel` out 3; `ARF_RegSel` out 3.
- `IR_LH` out 1; `IR_Write` out 1.
- `Mem_WR` out 1; `Mem_CS` out 1.
- `MuxASel`, `MuxBSel` out 2 each; `MuxCSel` out 1.
- `Halted` out 1: high in HALT state.

## Operation
Control encodings (the constants in `cu_pkg`, which also define the test-plan values below):
- RegSel bits are 1 = register updates.
  - RF_RegSel bit i selects R(i+1).
  - ARF_RegSel is {PC,AR,SP}.
- FunSel codes: INC=3'b001, LOAD=3'b010, CLEAR=3'b011.
- ARF_OutDSel: PC=2'b00, AR=2'b01.
- ALU_FunSel: PASS_A=5'b10000, INC_A=5'b10100, ADD=5'b10110, AND=5'b10111.
- Memory: Mem_CS=0 enables; Mem_WR=1 writes.

IDLE output vector (all control outputs default to this unless a cycle below overrides them):
- All RegSel = 0, ScrSel = 0, IR_Write = 0, Mem_CS = 1, Mem_WR = 0, ALU_WF = 0.
- All selects and FunSels = 0.

States: RUN, HALT. Timing counter T counts 0..3; all outputs are combinational from (state, T, IROut, ALUOutFlag).

Fetch (every instruction):
- T0: OutDSel=PC, Mem_CS=0, IR_Write=1, IR_LH=0; ARF PC INC.
- T1: same as T0 with IR_LH=1.

Execute:
- T2: execute the instruction below. Single-cycle instructions then reset T to 0.
- T3: used only by ADD and AND.

Opcodes:
- 0x00 NOP.
- 0x01 BRA: MuxBSel=2'b11, ARF PC LOAD.
- 0x02 BNE: as BRA only when Z=0; else NOP.
- 0x03 IMM: MuxASel=2'b11, RF Rx LOAD (zero-extended).
- 0x04 LD: OutDSel=AR, Mem_CS=0, MuxASel=2'b10, RF Rx LOAD; ARF AR INC in the same cycle.
- 0x05 ST: OutASel=Rx, ALU PASS_A, MuxCSel=0, OutDSel=AR, Mem_CS=0, Mem_WR=1; AR INC.
- 0x06 INC: OutASel=Rx, ALU INC_A, ALU_WF=1, MuxASel=2'b00, RF Rx LOAD.
- 0x07 ADD / 0x08 AND: two cycles.
  - T2: OutASel=Rx, OutBSel=R1, ALU op with ALU_WF=1, MuxASel=0, load S1 via ScrSel bit 0.
  - T3: OutASel=S1 (3'b100), PASS_A, RF Rx LOAD.
- 0x09 LDAR: MuxBSel=2'b11, ARF AR LOAD.
- 0x3F HLT: enter HALT.
- Any other opcode: NOP.

HALT:
- All outputs IDLE; T holds at 0.
- Leaves HALT only via Reset.

## Timing
Instruction latency:
- 3 cycles for all single-cycle instructions.
- 4 cycles for ADD/AND.
- BNE is 3 cycles whether taken or not.

Flag and branch timing:
- BNE samples Z combinationally in T2.
- Z is the flag registered by the latest preceding ALU_WF=1 cycle.

Reset:
- While Reset=1: outputs IDLE except ARF_RegSel=PC, ARF_FunSel=CLEAR, so PC=0 after the edge.
- On the edge with Reset=1: T←0, state←RUN, Halted←0.
- Reset mid-instruction aborts it; no partial write occurs after the reset cycle.

Boundary cases:
- T never exceeds 3. An illegal T value recovers to T0 on the next edge.
- PC/AR wrap is the ARF's concern; the control unit only issues INC.

## Structure
- `cu_pkg`:
  - opcode enum.
  - state enum {RUN, HALT}.
  - FunSel, RegSel-bit, MuxSel, OutSel and ALU_FunSel constants.
  - IDLE default values.
- Sub-module `seq_counter` (T_W bits): synchronous clear, increment, hold.
- Top: state register, counter instance, one combinational decode block that assigns IDLE first, then overrides.

## Test plan
- Reset held 2 cycles → PC CLEAR driven on both cycles, outputs otherwise IDLE; Halted=0, T=0 after release.
- IR=0x0C5A (IMM, R1, 0x5A) → T0/T1 fetch signals exact; T2 MuxASel=2'b11, RF_RegSel=4'b0001, RF_FunSel=3'b010; T returns to 0.
- BNE 0x08F0 with Z=1 → T2 ARF_RegSel=0. With Z=0 → ARF_RegSel=3'b100, FunSel=LOAD, MuxBSel=2'b11.
- ADD R2 (0x1D00) → T2 ALU_FunSel=5'b10110, ALU_WF=1, RF_ScrSel=4'b0001. T3 RF_OutASel=3'b100, RF_RegSel=4'b0010. Next instruction starts at cycle 4.
- ST R3 → Mem_CS=0, Mem_WR=1, ARF_OutDSel=2'b01, ARF_RegSel=3'b010 INC, all in T2 only.
- HLT, then 5 idle cycles → Halted=1 with IDLE outputs throughout. Reset mid-ADD at T2 → next cycle T=0, no RF load.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, FSM states,
// datapath control field codes and the IDLE control vector.
package cu_pkg;

    typedef enum logic [5:0] {
        OpNop  = 6'h00,
        OpBra  = 6'h01,
        OpBne  = 6'h02,
        OpImm  = 6'h03,
        OpLd   = 6'h04,
        OpSt   = 6'h05,
        OpInc  = 6'h06,
        OpAdd  = 6'h07,
        OpAnd  = 6'h08,
        OpLdar = 6'h09,
        OpHlt  = 6'h3F
    } opcode_e;

    typedef enum logic {
        StRun,
        StHalt
    } state_e;

    localparam logic [2:0] FunInc   = 3'b001;
    localparam logic [2:0] FunLoad  = 3'b010;
    localparam logic [2:0] FunClear = 3'b011;

    // ARF_RegSel is {PC, AR, SP}
    localparam logic [2:0] ArfPc = 3'b100;
    localparam logic [2:0] ArfAr = 3'b010;
    localparam logic [2:0] ArfSp = 3'b001;

    localparam logic [3:0] ScrS1 = 4'b0001;

    localparam logic [1:0] OutDPc = 2'b00;
    localparam logic [1:0] OutDAr = 2'b01;

    localparam logic [2:0] OutR1 = 3'b000;
    localparam logic [2:0] OutS1 = 3'b100;

    localparam logic [1:0] MuxAAlu = 2'b00;
    localparam logic [1:0] MuxAMem = 2'b10;
    localparam logic [1:0] MuxAImm = 2'b11;
    localparam logic [1:0] MuxBImm = 2'b11;
    localparam logic       MuxCLo  = 1'b0;

    localparam logic [4:0] AluPassA = 5'b10000;
    localparam logic [4:0] AluIncA  = 5'b10100;
    localparam logic [4:0] AluAdd   = 5'b10110;
    localparam logic [4:0] AluAnd   = 5'b10111;

    typedef struct packed {
        logic [2:0] rf_outa_sel;
        logic [2:0] rf_outb_sel;
        logic [2:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] rf_scr_sel;
        logic [4:0] alu_fun_sel;
        logic       alu_wf;
        logic [1:0] arf_outc_sel;
        logic [1:0] arf_outd_sel;
        logic [2:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
    } ctrl_t;

    // Memory chip select is active-low, so IDLE keeps it deasserted.
    localparam ctrl_t CtrlIdle = '{mem_cs: 1'b1, default: '0};

    function automatic logic [3:0] rf_onehot(input logic [1:0] rx);
        return 4'b0001 << rx;
    endfunction

    function automatic logic [2:0] rf_outsel(input logic [1:0] rx);
        return {1'b0, rx};
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Timing counter T: synchronous clear (reset or clr), increment, else hold.
module seq_counter #(
    parameter int unsigned T_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    output logic [T_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + T_W'(1);
        end
    end

endmodule

// File: rtl/hardwired_control_unit.sv
// Hardwired fetch/decode/execute sequencer driving every datapath control input;
// all outputs are combinational from (state, T, IROut, ALUOutFlag).
module hardwired_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned T_W = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted
);

    localparam logic [T_W-1:0] TStep0 = T_W'(0);
    localparam logic [T_W-1:0] TStep1 = T_W'(1);
    localparam logic [T_W-1:0] TStep2 = T_W'(2);
    localparam logic [T_W-1:0] TStep3 = T_W'(3);

    state_e         state_q, state_d;
    logic [T_W-1:0] t;
    logic           cnt_clr, cnt_inc;
    ctrl_t          ctrl;
    logic [5:0]     opcode;
    logic [1:0]     rx;
    logic           two_cycle;
    logic           unused_bits;

    assign opcode      = IROut[15:10];
    assign rx          = IROut[9:8];
    assign two_cycle   = (opcode == OpAdd) || (opcode == OpAnd);
    assign unused_bits = ^{IROut[7:0], ALUOutFlag[2:0]};

    seq_counter #(
        .T_W(T_W)
    ) u_seq_counter (
        .clk  (Clock),
        .rst  (Reset),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(t)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl    = CtrlIdle;
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (Reset) begin
            ctrl.arf_reg_sel = ArfPc;
            ctrl.arf_fun_sel = FunClear;
        end else if (state_q == StHalt) begin
            cnt_clr = 1'b1;
        end else begin
            case (t)
                TStep0, TStep1: begin
                    ctrl.arf_outd_sel = OutDPc;
                    ctrl.mem_cs       = 1'b0;
                    ctrl.ir_write     = 1'b1;
                    ctrl.ir_lh        = (t == TStep1);
                    ctrl.arf_reg_sel  = ArfPc;
                    ctrl.arf_fun_sel  = FunInc;
                    cnt_inc           = 1'b1;
                end
                TStep2: begin
                    cnt_clr = 1'b1;
                    case (opcode)
                        OpBra: begin
                            ctrl.mux_b_sel   = MuxBImm;
                            ctrl.arf_reg_sel = ArfPc;
                            ctrl.arf_fun_sel = FunLoad;
                        end
                        OpBne: begin
                            if (!ALUOutFlag[3]) begin
                                ctrl.mux_b_sel   = MuxBImm;
                                ctrl.arf_reg_sel = ArfPc;
                                ctrl.arf_fun_sel = FunLoad;
                            end
                        end
                        OpImm: begin
                            ctrl.mux_a_sel  = MuxAImm;
                            ctrl.rf_reg_sel = rf_onehot(rx);
                            ctrl.rf_fun_sel = FunLoad;
                        end
                        OpLd: begin
                            ctrl.arf_outd_sel = OutDAr;
                            ctrl.mem_cs       = 1'b0;
                            ctrl.mux_a_sel    = MuxAMem;
                            ctrl.rf_reg_sel   = rf_onehot(rx);
                            ctrl.rf_fun_sel   = FunLoad;
                            ctrl.arf_reg_sel  = ArfAr;
                            ctrl.arf_fun_sel  = FunInc;
                        end
                        OpSt: begin
                            ctrl.rf_outa_sel  = rf_outsel(rx);
                            ctrl.alu_fun_sel  = AluPassA;
                            ctrl.mux_c_sel    = MuxCLo;
                            ctrl.arf_outd_sel = OutDAr;
                            ctrl.mem_cs       = 1'b0;
                            ctrl.mem_wr       = 1'b1;
                            ctrl.arf_reg_sel  = ArfAr;
                            ctrl.arf_fun_sel  = FunInc;
                        end
                        OpInc: begin
                            ctrl.rf_outa_sel = rf_outsel(rx);
                            ctrl.alu_fun_sel = AluIncA;
                            ctrl.alu_wf      = 1'b1;
                            ctrl.mux_a_sel   = MuxAAlu;
                            ctrl.rf_reg_sel  = rf_onehot(rx);
                            ctrl.rf_fun_sel  = FunLoad;
                        end
                        OpAdd, OpAnd: begin
                            // Result parks in scratch S1 and is written back in T3.
                            ctrl.rf_outa_sel = rf_outsel(rx);
                            ctrl.rf_outb_sel = OutR1;
                            ctrl.alu_fun_sel = (opcode == OpAdd) ? AluAdd : AluAnd;
                            ctrl.alu_wf      = 1'b1;
                            ctrl.mux_a_sel   = MuxAAlu;
                            ctrl.rf_scr_sel  = ScrS1;
                            ctrl.rf_fun_sel  = FunLoad;
                            cnt_clr          = 1'b0;
                            cnt_inc          = 1'b1;
                        end
                        OpLdar: begin
                            ctrl.mux_b_sel   = MuxBImm;
                            ctrl.arf_reg_sel = ArfAr;
                            ctrl.arf_fun_sel = FunLoad;
                        end
                        OpHlt: begin
                            state_d = StHalt;
                        end
                        default: begin
                        end
                    endcase
                end
                TStep3: begin
                    cnt_clr = 1'b1;
                    if (two_cycle) begin
                        ctrl.rf_outa_sel = OutS1;
                        ctrl.alu_fun_sel = AluPassA;
                        ctrl.mux_a_sel   = MuxAAlu;
                        ctrl.rf_reg_sel  = rf_onehot(rx);
                        ctrl.rf_fun_sel  = FunLoad;
                    end
                end
                default: begin
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    assign RF_OutASel  = ctrl.rf_outa_sel;
    assign RF_OutBSel  = ctrl.rf_outb_sel;
    assign RF_FunSel   = ctrl.rf_fun_sel;
    assign RF_RegSel   = ctrl.rf_reg_sel;
    assign RF_ScrSel   = ctrl.rf_scr_sel;
    assign ALU_FunSel  = ctrl.alu_fun_sel;
    assign ALU_WF      = ctrl.alu_wf;
    assign ARF_OutCSel = ctrl.arf_outc_sel;
    assign ARF_OutDSel = ctrl.arf_outd_sel;
    assign ARF_FunSel  = ctrl.arf_fun_sel;
    assign ARF_RegSel  = ctrl.arf_reg_sel;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Write    = ctrl.ir_write;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign MuxASel     = ctrl.mux_a_sel;
    assign MuxBSel     = ctrl.mux_b_sel;
    assign MuxCSel     = ctrl.mux_c_sel;
    assign Halted      = (state_q == StHalt);

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Directed bench for hardwired_control_unit: the bench plays the datapath,
// driving IROut/ALUOutFlag and checking the full control vector every cycle.
module tb_hardwired_control_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;

    typedef struct packed {
        logic [2:0] outa;
        logic [2:0] outb;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] outc;
        logic [1:0] outd;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_wr;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
    } vec_t;

    vec_t obs, idle_v, rst_v, f0_v, f1_v;
    int   n_checks = 0;
    int   n_fail   = 0;

    assign obs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
                  ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR,
                  Mem_CS, MuxASel, MuxBSel, MuxCSel};

    always #5 Clock = ~Clock;

    hardwired_control_unit #(
        .T_W(3)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .IROut      (IROut),
        .ALUOutFlag (ALUOutFlag),
        .RF_OutASel (RF_OutASel),
        .RF_OutBSel (RF_OutBSel),
        .RF_FunSel  (RF_FunSel),
        .RF_RegSel  (RF_RegSel),
        .RF_ScrSel  (RF_ScrSel),
        .ALU_FunSel (ALU_FunSel),
        .ALU_WF     (ALU_WF),
        .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel (ARF_FunSel),
        .ARF_RegSel (ARF_RegSel),
        .IR_LH      (IR_LH),
        .IR_Write   (IR_Write),
        .Mem_WR     (Mem_WR),
        .Mem_CS     (Mem_CS),
        .MuxASel    (MuxASel),
        .MuxBSel    (MuxBSel),
        .MuxCSel    (MuxCSel),
        .Halted     (Halted)
    );

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic test_reset();
        Reset      = 1'b1;
        IROut      = 16'h0000;
        ALUOutFlag = 4'b0000;
        #2;
        n_checks++;
        if (obs !== rst_v) begin
            n_fail++;
            $display("FAIL reset_cycle1: got %h want %h", obs, rst_v);
        end
        step();
        n_checks++;
        if (obs !== rst_v) begin
            n_fail++;
            $display("FAIL reset_cycle2: got %h want %h", obs, rst_v);
        end
        step();
        Reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== f0_v || Halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got %h halted %b want %h halted 0", obs, Halted, f0_v);
        end
    endtask

    task automatic test_imm();
        vec_t seq [4];
        seq[0] = f0_v;
        seq[1] = f1_v;
        seq[2] = idle_v;
        seq[2].mux_a  = 2'b11;
        seq[2].rf_reg = 4'b0001;
        seq[2].rf_fun = 3'b010;
        seq[3] = f0_v;
        IROut = 16'h0C5A;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            #1;
            n_checks++;
            if (obs !== seq[c]) begin
                n_fail++;
                $display("FAIL imm cycle %0d: got %h want %h", c, obs, seq[c]);
            end
        end
    endtask

    task automatic test_bne();
        vec_t seq [3];
        vec_t taken;
        taken = idle_v;
        taken.mux_b   = 2'b11;
        taken.arf_reg = 3'b100;
        taken.arf_fun = 3'b010;
        seq[0] = f0_v;
        seq[1] = f1_v;
        IROut = 16'h08F0;
        for (int pass = 0; pass < 2; pass++) begin
            // Only Z may steer the branch, so the other flags are held high.
            ALUOutFlag = (pass == 0) ? 4'b1111 : 4'b0111;
            seq[2] = (pass == 0) ? idle_v : taken;
            for (int c = 0; c < 3; c++) begin
                if (c > 0) step();
                #1;
                n_checks++;
                if (obs !== seq[c]) begin
                    n_fail++;
                    $display("FAIL bne pass %0d cycle %0d: got %h want %h", pass, c, obs, seq[c]);
                end
            end
            step();
        end
        #1;
        n_checks++;
        if (obs !== f0_v) begin
            n_fail++;
            $display("FAIL bne_next_t0: got %h want %h", obs, f0_v);
        end
        ALUOutFlag = 4'b0000;
    endtask

    task automatic test_single();
        logic [15:0] irs [6];
        vec_t        t2s [6];
        irs[0] = 16'h0400;
        t2s[0] = idle_v; t2s[0].mux_b = 2'b11; t2s[0].arf_reg = 3'b100; t2s[0].arf_fun = 3'b010;
        irs[1] = 16'h1100;
        t2s[1] = idle_v; t2s[1].outd = 2'b01; t2s[1].mem_cs = 1'b0; t2s[1].mux_a = 2'b10;
        t2s[1].rf_reg = 4'b0010; t2s[1].rf_fun = 3'b010;
        t2s[1].arf_reg = 3'b010; t2s[1].arf_fun = 3'b001;
        irs[2] = 16'h1800;
        t2s[2] = idle_v; t2s[2].outa = 3'b000; t2s[2].alu_fun = 5'b10100; t2s[2].alu_wf = 1'b1;
        t2s[2].rf_reg = 4'b0001; t2s[2].rf_fun = 3'b010;
        irs[3] = 16'h2400;
        t2s[3] = idle_v; t2s[3].mux_b = 2'b11; t2s[3].arf_reg = 3'b010; t2s[3].arf_fun = 3'b010;
        irs[4] = 16'h5400;
        t2s[4] = idle_v;
        irs[5] = 16'h0000;
        t2s[5] = idle_v;
        for (int i = 0; i < 6; i++) begin
            IROut = irs[i];
            for (int c = 0; c < 3; c++) begin
                if (c > 0) step();
                #1;
                n_checks++;
                if (obs !== ((c == 0) ? f0_v : (c == 1) ? f1_v : t2s[i])) begin
                    n_fail++;
                    $display("FAIL single ir %h cycle %0d: got %h", irs[i], c, obs);
                end
            end
            step();
        end
    endtask

    task automatic test_two_cycle(input logic [15:0] ir, input logic [4:0] alu,
                                  input logic [2:0] outa, input logic [3:0] dest);
        vec_t seq [5];
        seq[0] = f0_v;
        seq[1] = f1_v;
        seq[2] = idle_v;
        seq[2].outa    = outa;
        seq[2].outb    = 3'b000;
        seq[2].alu_fun = alu;
        seq[2].alu_wf  = 1'b1;
        seq[2].rf_scr  = 4'b0001;
        seq[2].rf_fun  = 3'b010;
        seq[3] = idle_v;
        seq[3].outa    = 3'b100;
        seq[3].alu_fun = 5'b10000;
        seq[3].rf_reg  = dest;
        seq[3].rf_fun  = 3'b010;
        seq[4] = f0_v;
        IROut = ir;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) step();
            #1;
            n_checks++;
            if (obs !== seq[c]) begin
                n_fail++;
                $display("FAIL two_cycle ir %h cycle %0d: got %h want %h", ir, c, obs, seq[c]);
            end
        end
    endtask

    task automatic test_st();
        vec_t seq [4];
        seq[0] = f0_v;
        seq[1] = f1_v;
        seq[2] = idle_v;
        seq[2].outa    = 3'b010;
        seq[2].alu_fun = 5'b10000;
        seq[2].mux_c   = 1'b0;
        seq[2].outd    = 2'b01;
        seq[2].mem_cs  = 1'b0;
        seq[2].mem_wr  = 1'b1;
        seq[2].arf_reg = 3'b010;
        seq[2].arf_fun = 3'b001;
        seq[3] = f0_v;
        IROut = 16'h1600;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            #1;
            n_checks++;
            if (obs !== seq[c]) begin
                n_fail++;
                $display("FAIL st cycle %0d: got %h want %h", c, obs, seq[c]);
            end
        end
    endtask

    task automatic test_halt();
        IROut = 16'hFC00;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            #1;
            n_checks++;
            if (obs !== ((c == 0) ? f0_v : (c == 1) ? f1_v : idle_v) || Halted !== 1'b0) begin
                n_fail++;
                $display("FAIL hlt cycle %0d: got %h halted %b", c, obs, Halted);
            end
        end
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            n_checks++;
            if (obs !== idle_v || Halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halted idle %0d: got %h halted %b want %h halted 1",
                         c, obs, Halted, idle_v);
            end
        end
    endtask

    task automatic test_reset_mid_add();
        vec_t add_t2;
        add_t2 = idle_v;
        add_t2.outa    = 3'b001;
        add_t2.alu_fun = 5'b10110;
        add_t2.alu_wf  = 1'b1;
        add_t2.rf_scr  = 4'b0001;
        add_t2.rf_fun  = 3'b010;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== rst_v) begin
            n_fail++;
            $display("FAIL halt_reset: got %h want %h", obs, rst_v);
        end
        step();
        Reset = 1'b0;
        IROut = 16'h1D00;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            #1;
            n_checks++;
            if (obs !== ((c == 0) ? f0_v : (c == 1) ? f1_v : add_t2) || Halted !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_add cycle %0d: got %h halted %b", c, obs, Halted);
            end
        end
        Reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== rst_v) begin
            n_fail++;
            $display("FAIL mid_add_reset: got %h want %h", obs, rst_v);
        end
        step();
        Reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== f0_v || Halted !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_add_after: got %h halted %b want %h", obs, Halted, f0_v);
        end
        step();
        #1;
        n_checks++;
        if (obs !== f1_v) begin
            n_fail++;
            $display("FAIL mid_add_refetch: got %h want %h", obs, f1_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_v = '0;
        idle_v.mem_cs = 1'b1;
        rst_v = idle_v;
        rst_v.arf_reg = 3'b100;
        rst_v.arf_fun = 3'b011;
        f0_v = idle_v;
        f0_v.outd    = 2'b00;
        f0_v.mem_cs  = 1'b0;
        f0_v.ir_wr   = 1'b1;
        f0_v.arf_reg = 3'b100;
        f0_v.arf_fun = 3'b001;
        f1_v = f0_v;
        f1_v.ir_lh = 1'b1;

        test_reset();
        test_imm();
        test_bne();
        test_single();
        test_two_cycle(16'h1D00, 5'b10110, 3'b001, 4'b0010);
        test_two_cycle(16'h2300, 5'b10111, 3'b011, 4'b1000);
        test_st();
        test_halt();
        test_reset_mid_add();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
